// File: rtl/dmem_responder.sv
// dmem_responder: zero-latency data memory fronted by a store buffer that drains on idle cycles.
// Optional `DMEM_COALESCE_EN merges a store into the youngest buffered entry with the same index.
module dmem_responder #(
  parameter int N = 64,
  parameter int AW = 6,
  parameter int SB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N-1:0]               addr,
  input  logic [N-1:0]               writeData,
  input  logic                       memWrite,
  input  logic                       memRead,
  output logic [N-1:0]               readData,
  output logic [$clog2(SB_DEPTH):0]  sb_count,
  output logic                       sb_full
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  logic [N-1:0]        r_mem [2**AW];
  logic [AW-1:0]       r_idx [SB_DEPTH];
  logic [N-1:0]        r_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] r_vld;
  logic [PW-1:0]       r_head, r_tail;
  logic [CW-1:0]       r_count;
  logic [AW-1:0]       w_idx;
  logic [PW-1:0]       w_slot;
  logic                w_hit, w_full, w_coal, w_enq, w_drain, w_unused;
  assign w_idx = addr[AW+2:3];
  assign w_unused = ^{addr[N-1:AW+3], addr[2:0]};
  // Scan oldest to youngest so the last match (youngest store) wins
  always_comb begin
    w_hit = 1'b0;
    w_slot = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (r_vld[r_head + PW'(k)] && r_idx[r_head + PW'(k)] == w_idx) begin
        w_hit = 1'b1;
        w_slot = r_head + PW'(k);
      end
    end
  end
  assign w_full = r_count == CW'(SB_DEPTH);
`ifdef DMEM_COALESCE_EN
  assign w_coal = memWrite && w_hit;
`else
  assign w_coal = 1'b0;
`endif
  assign w_enq = memWrite && !w_coal;
  // Single array port: drain only when it is free, or to make room for a store into a full buffer
  assign w_drain = r_count != '0 && ((!memRead && !memWrite) || (w_enq && w_full));
  assign readData = memRead ? (w_hit ? r_data[w_slot] : r_mem[w_idx]) : '0;
  assign sb_count = r_count;
  assign sb_full = w_full;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      if (w_drain) r_vld[r_head] <= 1'b0;
      if (w_enq) r_vld[r_tail] <= 1'b1;
      r_head <= r_head + PW'(w_drain);
      r_tail <= r_tail + PW'(w_enq);
      r_count <= r_count + CW'(w_enq) - CW'(w_drain);
    end
  end
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_idx[r_tail] <= w_idx;
      r_data[r_tail] <= writeData;
    end
    if (w_coal) r_data[w_slot] <= writeData;
    if (w_drain) r_mem[r_idx[r_head]] <= r_data[r_head];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector table plus hand sequences for reset and load/store overlap.
module tb_dmem_responder;
  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] e;
    int          c;
  } vec_t;
`ifdef DMEM_COALESCE_EN
  localparam int DUP = 1;
`else
  localparam int DUP = 2;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memWrite = 1'b0;
  logic        memRead = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] writeData = '0;
  logic [63:0] readData;
  logic [2:0]  sb_count;
  logic        sb_full;
  int          checks = 0;
  int          failures = 0;
  vec_t        tbl[$];

  dmem_responder dut (
    .clk(clk), .reset(reset), .addr(addr), .writeData(writeData),
    .memWrite(memWrite), .memRead(memRead), .readData(readData),
    .sb_count(sb_count), .sb_full(sb_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                      input logic [63:0] e, input int c, input string tag);
    @(negedge clk);
    memRead = rd;
    memWrite = wr;
    addr = a;
    writeData = d;
    #2;
    chk({tag, " readData"}, readData, e);
    chk({tag, " sb_count"}, 64'(sb_count), 64'(c));
    chk({tag, " sb_full"}, 64'(sb_full), 64'(c == 4));
  endtask

  task automatic add(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                     input logic [63:0] e, input int c);
    tbl.push_back('{rd, wr, a, d, e, c});
  endtask

  initial begin
    add(0, 1, 64'h10, 64'hDEAD_BEEF, 0, 0);
    add(1, 0, 64'h10, 0, 64'hDEAD_BEEF, 1);
    add(0, 0, 64'h10, 0, 0, 1);
    add(1, 0, 64'h10, 0, 64'hDEAD_BEEF, 0);
    add(0, 1, 64'h00, 1, 0, 0);
    add(0, 1, 64'h08, 2, 0, 1);
    add(0, 1, 64'h10, 3, 0, 2);
    add(0, 1, 64'h18, 4, 0, 3);
    add(0, 1, 64'h20, 5, 0, 4);
    add(1, 0, 64'h00, 0, 1, 4);
    add(0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 1);
    add(1, 0, 64'h00, 0, 1, 0);
    add(1, 0, 64'h08, 0, 2, 0);
    add(1, 0, 64'h10, 0, 3, 0);
    add(1, 0, 64'h18, 0, 4, 0);
    add(1, 0, 64'h20, 0, 5, 0);
    add(0, 1, 64'h08, 64'hA, 0, 0);
    add(0, 1, 64'h08, 64'hB, 0, 1);
    add(1, 0, 64'h08, 0, 64'hB, DUP);
    add(0, 0, 0, 0, 0, DUP);
    add(0, 0, 0, 0, 0, DUP - 1);
    add(1, 0, 64'h08, 0, 64'hB, 0);
    add(1, 0, 64'h208, 0, 64'hB, 0);
    add(0, 0, 64'h08, 0, 0, 0);
    add(0, 1, 64'h30, 64'h77, 0, 0);
    add(0, 1, 64'h38, 64'h88, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 0, (i % 2) ? 64'h38 : 64'h30, 0, (i % 2) ? 64'h88 : 64'h77, 2);
    add(0, 0, 0, 0, 0, 2);
    add(1, 0, 64'h38, 0, 64'h88, 1);
    add(0, 0, 0, 0, 0, 1);
    add(1, 0, 64'h30, 0, 64'h77, 0);
    add(1, 0, 64'h3F, 0, 64'h88, 0);

    #2;
    chk("reset sb_count", 64'(sb_count), 0);
    chk("reset sb_full", 64'(sb_full), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].c, $sformatf("vec%0d", i));

    // Reset with three undrained stores: they vanish, drained data survives
    step(0, 1, 64'h00, 64'h111, 0, 0, "rst st0");
    step(0, 1, 64'h08, 64'h222, 0, 1, "rst st1");
    step(0, 1, 64'h10, 64'h333, 0, 2, "rst st2");
    @(posedge clk);
    #2;
    memWrite = 1'b0;
    reset = 1'b1;
    #1;
    chk("midreset sb_count", 64'(sb_count), 0);
    chk("midreset sb_full", 64'(sb_full), 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 64'h00, 0, 1, 0, "postrst ld0");
    step(1, 0, 64'h08, 0, 64'hB, 0, "postrst ld1");
    step(1, 0, 64'h10, 0, 3, 0, "postrst ld2");

    // Simultaneous load and store: load sees pre-edge state, store still lands
    step(1, 1, 64'h00, 64'h9, 1, 0, "rdwr both");
    step(1, 0, 64'h00, 0, 64'h9, 1, "rdwr after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
